// File: rtl/alarm_sequencer_pkg.sv
// Shared types and constants for the alarm sequencer.
// State encoding, time-field widths and escalation timing.
package alarm_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZING = 2'd3
    } al_state_t;

    localparam int SECS_PER_MIN = 60;
    localparam int ESCALATE_SEC = 20;
    localparam int HOUR_W       = 5;
    localparam int MIN_W        = 6;

endpackage

// File: rtl/alarm_sequencer_match_detect.sv
// Alarm-time comparator with a registered copy for rising-edge trigger.
// trig fires once when the qualified match first becomes true.
module alarm_match_detect
    import alarm_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [HOUR_W-1:0] al_hour,
    input  logic [MIN_W-1:0]  al_min,
    input  logic              alarm_on,
    input  logic              adjusting,
    output logic              trig
);

    logic match;
    logic match_q;

    assign match = (cur_hour == al_hour) && (cur_min == al_min)
                 && alarm_on && !adjusting;

    always_ff @(posedge clk) begin
        if (!reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    assign trig = match && !match_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/dismiss sequencer with registered outputs.
// Optional ALARM_ESCALATE_EN pulses the buzzer during early ringing.
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int SNOOZE_MIN       = 5,
    parameter int MAX_SNOOZE       = 3,
    parameter int RING_TIMEOUT_SEC = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [HOUR_W-1:0] al_hour,
    input  logic [MIN_W-1:0]  al_min,
    input  logic              alarm_on,
    input  logic              adjusting,
    input  logic              btn_snooze,
    input  logic              btn_dismiss,
    output logic              ringing,
    output logic              buzzer_en,
    output logic              snoozing,
    output logic [2:0]        snooze_cnt,
    output logic              armed
);

    localparam int SNZ_LOAD = SNOOZE_MIN * SECS_PER_MIN;
    localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);

    localparam logic [SNZ_W-1:0] SNZ_INIT = SNZ_W'(SNZ_LOAD);
    localparam logic [SNZ_W-1:0] SNZ_ONE  = SNZ_W'(1);
    localparam logic [7:0]       RT_LAST  = 8'(RING_TIMEOUT_SEC - 1);
    localparam logic [2:0]       MAXS     = 3'(MAX_SNOOZE);

    al_state_t        state, state_nx;
    logic [7:0]       ring_sec, ring_nx;
    logic [SNZ_W-1:0] snz_left, snz_nx;
    logic [2:0]       cnt_nx;
    logic             buzz_nx;
    logic             trig;

    alarm_match_detect u_match (
        .clk       (clk),
        .reset     (reset),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .al_hour   (al_hour),
        .al_min    (al_min),
        .alarm_on  (alarm_on),
        .adjusting (adjusting),
        .trig      (trig)
    );

    always_comb begin
        state_nx = state;
        ring_nx  = ring_sec;
        snz_nx   = snz_left;
        cnt_nx   = snooze_cnt;
        if (!alarm_on) begin
            state_nx = IDLE;
            ring_nx  = '0;
            snz_nx   = '0;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                // A match already present when the switch comes on still rings
                IDLE: begin
                    state_nx = trig ? RINGING : ARMED;
                    ring_nx  = '0;
                    cnt_nx   = '0;
                end
                ARMED: begin
                    if (trig) begin
                        state_nx = RINGING;
                        ring_nx  = '0;
                        cnt_nx   = '0;
                    end
                end
                RINGING: begin
                    if (btn_dismiss) begin
                        state_nx = ARMED;
                        ring_nx  = '0;
                        cnt_nx   = '0;
                    end else if (btn_snooze && snooze_cnt < MAXS) begin
                        state_nx = SNOOZING;
                        ring_nx  = '0;
                        snz_nx   = SNZ_INIT;
                        cnt_nx   = snooze_cnt + 3'd1;
                    end else if (tick_1hz) begin
                        if (ring_sec == RT_LAST) begin
                            state_nx = ARMED;
                            ring_nx  = '0;
                            cnt_nx   = '0;
                        end else begin
                            ring_nx = ring_sec + 8'd1;
                        end
                    end
                end
                SNOOZING: begin
                    if (btn_dismiss) begin
                        state_nx = ARMED;
                        snz_nx   = '0;
                        cnt_nx   = '0;
                    end else if (tick_1hz) begin
                        if (snz_left == SNZ_ONE) begin
                            state_nx = RINGING;
                            ring_nx  = '0;
                            snz_nx   = '0;
                        end else begin
                            snz_nx = snz_left - SNZ_ONE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ALARM_ESCALATE_EN
    // Even seconds of ringing sound, odd ones are silent, until escalation ends
    assign buzz_nx = (state_nx == RINGING)
                   && (ring_nx >= 8'(ESCALATE_SEC) || !ring_nx[0]);
`else
    assign buzz_nx = (state_nx == RINGING);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ring_sec   <= '0;
            snz_left   <= '0;
            snooze_cnt <= '0;
            ringing    <= 1'b0;
            buzzer_en  <= 1'b0;
            snoozing   <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nx;
            ring_sec   <= ring_nx;
            snz_left   <= snz_nx;
            snooze_cnt <= cnt_nx;
            ringing    <= (state_nx == RINGING);
            buzzer_en  <= buzz_nx;
            snoozing   <= (state_nx == SNOOZING);
            armed      <= (state_nx == ARMED);
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios plus random traffic,
// all checked against a seconds-counting reference model.
module tb_alarm_sequencer;

    localparam int SNOOZE_MIN = 5;
    localparam int MAX_SNOOZE = 3;
    localparam int TIMEOUT    = 60;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RING = 2;
    localparam int M_SNZ  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hour = 5'd7;
    logic [5:0] cur_min = 6'd29;
    logic [4:0] al_hour = 5'd7;
    logic [5:0] al_min = 6'd30;
    logic       alarm_on = 1'b0;
    logic       adjusting = 1'b0;
    logic       btn_snooze = 1'b0;
    logic       btn_dismiss = 1'b0;
    logic       ringing, buzzer_en, snoozing, armed;
    logic [2:0] snooze_cnt;

    int total = 0;
    int bad = 0;

    int  m_mode = M_IDLE;
    int  m_el = 0;
    int  m_rem = 0;
    int  m_used = 0;
    bit  m_prev = 1'b0;
    logic [6:0] e_vec = '0;
    wire  [6:0] dut_vec = {ringing, buzzer_en, snoozing, armed, snooze_cnt};

    alarm_sequencer #(
        .SNOOZE_MIN       (SNOOZE_MIN),
        .MAX_SNOOZE       (MAX_SNOOZE),
        .RING_TIMEOUT_SEC (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .al_hour     (al_hour),
        .al_min      (al_min),
        .alarm_on    (alarm_on),
        .adjusting   (adjusting),
        .btn_snooze  (btn_snooze),
        .btn_dismiss (btn_dismiss),
        .ringing     (ringing),
        .buzzer_en   (buzzer_en),
        .snoozing    (snoozing),
        .snooze_cnt  (snooze_cnt),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit hit, fire, buz;
        if (!reset) begin
            m_mode = M_IDLE; m_el = 0; m_rem = 0; m_used = 0; m_prev = 0;
        end else begin
            hit = (cur_hour == al_hour) && (cur_min == al_min)
                  && alarm_on && !adjusting;
            fire = hit && !m_prev;
            m_prev = hit;
            if (!alarm_on) begin
                m_mode = M_IDLE; m_el = 0; m_rem = 0; m_used = 0;
            end else if (m_mode == M_IDLE || m_mode == M_ARM) begin
                if (fire) begin
                    m_mode = M_RING; m_el = 0; m_used = 0;
                end else begin
                    m_mode = M_ARM;
                end
            end else if (m_mode == M_RING) begin
                if (btn_dismiss) begin
                    m_mode = M_ARM; m_used = 0;
                end else if (btn_snooze && m_used < MAX_SNOOZE) begin
                    m_mode = M_SNZ; m_used++; m_rem = SNOOZE_MIN * 60;
                end else if (tick_1hz) begin
                    m_el++;
                    if (m_el == TIMEOUT) begin
                        m_mode = M_ARM; m_used = 0;
                    end
                end
            end else begin
                if (btn_dismiss) begin
                    m_mode = M_ARM; m_used = 0;
                end else if (tick_1hz) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_mode = M_RING; m_el = 0;
                    end
                end
            end
        end
`ifdef ALARM_ESCALATE_EN
        buz = (m_mode == M_RING) && (m_el >= 20 || (m_el % 2) == 0);
`else
        buz = (m_mode == M_RING);
`endif
        e_vec = {m_mode == M_RING, buz, m_mode == M_SNZ, m_mode == M_ARM,
                 3'(m_used)};
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_ticks(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            cyc();
            tick_1hz = 1'b0;
            total++;
            if (dut_vec !== e_vec) begin
                bad++;
                $display("FAIL %s tick %0d: got %b want %b", name, i, dut_vec, e_vec);
            end
            repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    task automatic retrigger();
        cur_min = 6'd31;
        cyc();
        cur_min = 6'd30;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        alarm_on = 1'b1;
        cyc();
        cyc();
        total++;
        if (dut_vec !== 7'd0) begin
            bad++;
            $display("FAIL reset: got %b want 0000000", dut_vec);
        end
        reset = 1'b1;
    endtask

    task automatic test_trigger();
        cur_min = 6'd29;
        cyc();
        cyc();
        total++;
        if (armed !== 1'b1 || ringing !== 1'b0) begin
            bad++;
            $display("FAIL armed_wait: got %b want armed only", dut_vec);
        end
        cur_min = 6'd30;
        cyc();
        total++;
        if (ringing !== 1'b1 || buzzer_en !== 1'b1 || snooze_cnt !== 3'd0) begin
            bad++;
            $display("FAIL ring_start: got %b want ringing/buzzer, cnt 0", dut_vec);
        end
        total++;
        if (dut_vec !== e_vec) begin
            bad++;
            $display("FAIL ring_model: got %b want %b", dut_vec, e_vec);
        end
    endtask

    task automatic test_snooze();
        for (int k = 1; k <= 3; k++) begin
            btn_snooze = 1'b1;
            cyc();
            btn_snooze = 1'b0;
            total++;
            if (snoozing !== 1'b1 || snooze_cnt !== 3'(k)) begin
                bad++;
                $display("FAIL snooze_%0d: got snz=%b cnt=%0d want 1/%0d",
                         k, snoozing, snooze_cnt, k);
            end
            run_ticks(SNOOZE_MIN * 60 - 1, "snooze_wait");
            total++;
            if (snoozing !== 1'b1) begin
                bad++;
                $display("FAIL snooze_early_%0d: got snz=%b want 1", k, snoozing);
            end
            run_ticks(1, "snooze_end");
            total++;
            if (ringing !== 1'b1 || snooze_cnt !== 3'(k)) begin
                bad++;
                $display("FAIL rering_%0d: got ring=%b cnt=%0d want 1/%0d",
                         k, ringing, snooze_cnt, k);
            end
        end
        btn_snooze = 1'b1;
        cyc();
        btn_snooze = 1'b0;
        total++;
        if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 3'd3) begin
            bad++;
            $display("FAIL snooze_limit: got %b want ringing, cnt 3", dut_vec);
        end
    endtask

    task automatic test_timeout();
        run_ticks(TIMEOUT - 1, "ring_wait");
        total++;
        if (ringing !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: got ring=%b want 1", ringing);
        end
        run_ticks(1, "ring_end");
        total++;
        if (armed !== 1'b1 || ringing !== 1'b0) begin
            bad++;
            $display("FAIL timeout: got %b want armed", dut_vec);
        end
        repeat (5) cyc();
        total++;
        if (ringing !== 1'b0 || armed !== 1'b1) begin
            bad++;
            $display("FAIL no_refire: got %b want armed", dut_vec);
        end
    endtask

    task automatic test_both_buttons();
        retrigger();
        run_ticks(3, "pre_both");
        btn_snooze = 1'b1;
        btn_dismiss = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        btn_snooze = 1'b0;
        btn_dismiss = 1'b0;
        tick_1hz = 1'b0;
        total++;
        if (armed !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 3'd0) begin
            bad++;
            $display("FAIL both_buttons: got %b want armed, cnt 0", dut_vec);
        end
    endtask

    task automatic test_adjust();
        cur_min = 6'd31;
        cyc();
        adjusting = 1'b1;
        cur_min = 6'd30;
        repeat (4) cyc();
        total++;
        if (ringing !== 1'b0 || armed !== 1'b1) begin
            bad++;
            $display("FAIL adjust_block: got %b want armed", dut_vec);
        end
        adjusting = 1'b0;
        cyc();
        total++;
        if (ringing !== 1'b1) begin
            bad++;
            $display("FAIL adjust_release: got ring=%b want 1", ringing);
        end
    endtask

    task automatic test_alarm_off();
        btn_snooze = 1'b1;
        cyc();
        btn_snooze = 1'b0;
        run_ticks(7, "pre_off");
        alarm_on = 1'b0;
        cyc();
        total++;
        if (dut_vec !== 7'd0) begin
            bad++;
            $display("FAIL alarm_off: got %b want 0000000", dut_vec);
        end
        cur_min = 6'd29;
        alarm_on = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid_ring();
        retrigger();
        run_ticks(2, "pre_rst");
        reset = 1'b0;
        cyc();
        total++;
        if (dut_vec !== 7'd0) begin
            bad++;
            $display("FAIL reset_mid_ring: got %b want 0000000", dut_vec);
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8000; i++) begin
            tick_1hz    = ($urandom_range(0, 1) == 1);
            btn_snooze  = ($urandom_range(0, 39) == 0);
            btn_dismiss = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) alarm_on = ~alarm_on;
            if ($urandom_range(0, 299) == 0) adjusting = ~adjusting;
            if ($urandom_range(0, 49) == 0) cur_min = 6'($urandom_range(29, 31));
            if ($urandom_range(0, 999) == 0) cur_hour = 5'($urandom_range(7, 8));
            reset = ($urandom_range(0, 2999) != 0);
            cyc();
            total++;
            if (dut_vec !== e_vec) begin
                bad++;
                $display("FAIL random cyc %0d: got %b want %b", i, dut_vec, e_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_snooze();
        test_timeout();
        test_both_buttons();
        test_adjust();
        test_alarm_off();
        test_reset_mid_ring();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
